// File: rtl/speaker_i2s_ctl.sv
// speaker_i2s_ctl: I2S output stage for the Pmod DAC. A free-running 9-bit frame counter
// provides MCLK/SCK/LRCK, and the latched stereo sample is shifted out on SDIN.
module speaker_i2s_ctl (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic [15:0] audio_left,
  input  logic [15:0] audio_right,
  output logic        audio_mclk,
  output logic        audio_sck,
  output logic        audio_lrck,
  output logic        audio_sdin,
  output logic        frame_req
);

  logic [8:0]  r_cnt;
  logic [15:0] r_hold_l;
  logic [15:0] r_hold_r;
  logic        r_sdin;

  logic [8:0]  w_cnt_next;
  logic [4:0]  w_slot;
  logic [3:0]  w_bit_idx;
  logic        w_frame_end;
  logic        w_slot_end;
  logic        w_sdin_next;

  assign w_cnt_next  = r_cnt + 9'd1;
  assign w_slot      = w_cnt_next[8:4];
  assign w_frame_end = (r_cnt == 9'd511);
  assign w_slot_end  = (r_cnt[3:0] == 4'd15);

  // Slot s maps to bit (-s mod 16): slots 1..16 give left bits 15..0, slots 17..31 give
  // right bits 15..1, and slot 0 gives the previous frame's right LSB (I2S delay bit).
  assign w_bit_idx = 4'd0 - w_slot[3:0];

  always_comb begin
    w_sdin_next = r_hold_r[w_bit_idx];
    if ((w_slot != 5'd0) && (w_slot <= 5'd16)) begin
      w_sdin_next = r_hold_l[w_bit_idx];
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 9'd0;
      r_hold_l <= 16'd0;
      r_hold_r <= 16'd0;
      r_sdin   <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      // Slot 0 reads the old right hold value; the reload lands on the same edge.
      if (w_slot_end) begin
        r_sdin <= w_sdin_next;
      end
      if (w_frame_end) begin
        r_hold_l <= audio_left;
        r_hold_r <= audio_right;
      end
    end
  end

  assign audio_mclk = r_cnt[1];
  assign audio_sck  = r_cnt[3];
  assign audio_lrck = r_cnt[8];
  assign audio_sdin = r_sdin;
  assign frame_req  = w_frame_end;

endmodule

// File: tb/tb_speaker_i2s_ctl.sv
// tb_speaker_i2s_ctl: scoreboard bench; stimulus pushes the expected SDIN bit for every
// SCK slot, and a monitor pops and compares on each SCK rise.
module tb_speaker_i2s_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] audio_left = 16'd0;
  logic [15:0] audio_right = 16'd0;
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic        audio_sdin;
  logic        frame_req;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] m_cnt;
  int         m_frame;
  logic       div_en = 1'b0;
  logic       mon_en = 1'b0;
  logic       prev_sck = 1'b0;
  logic       exp_q[$];

  speaker_i2s_ctl dut (
    .clk_100mhz  (clk),
    .rst_n       (rst_n),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .audio_mclk  (audio_mclk),
    .audio_sck   (audio_sck),
    .audio_lrck  (audio_lrck),
    .audio_sdin  (audio_sdin),
    .frame_req   (frame_req)
  );

  always #5 clk = ~clk;

  // Reference frame position.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 9'd0;
      m_frame <= 0;
    end else begin
      m_cnt <= m_cnt + 9'd1;
      if (m_cnt == 9'd511) m_frame <= m_frame + 1;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 60) $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mclk"}, audio_mclk, 1'b0);
    check({tag, "_sck"},  audio_sck,  1'b0);
    check({tag, "_lrck"}, audio_lrck, 1'b0);
    check({tag, "_sdin"}, audio_sdin, 1'b0);
    check({tag, "_frame_req"}, frame_req, 1'b0);
  endtask

  // Bit 31 is slot 0, bit 0 is slot 31.
  task automatic push_frame(input logic [31:0] f);
    for (int i = 31; i >= 0; i--) exp_q.push_back(f[i]);
  endtask

  task automatic wait_at(input int f, input int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_frame == f && int'(m_cnt) == c) && n < 20000);
    if (n >= 20000) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_at: frame %0d cnt %0d not reached, got frame %0d cnt %0d",
               f, c, m_frame, m_cnt);
    end
  endtask

  // Divider and frame strobe checks every cycle.
  always @(negedge clk) begin
    if (div_en) begin
      check("mclk", audio_mclk, m_cnt[1]);
      check("sck", audio_sck, m_cnt[3]);
      check("lrck", audio_lrck, m_cnt[8]);
      check("frame_req", frame_req, m_cnt == 9'd511);
    end
  end

  // SDIN monitor: the DAC samples on the SCK rise.
  always @(negedge clk) begin
    if (mon_en && audio_sck && !prev_sck) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sdin_underflow: got %b with no expected bit queued (frame %0d slot %0d)",
                 audio_sdin, m_frame, m_cnt[8:4]);
      end else begin
        check($sformatf("sdin_f%0d_s%0d", m_frame, m_cnt[8:4]), audio_sdin, exp_q.pop_front());
      end
    end
    prev_sck = audio_sck;
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    @(negedge clk);
    div_en = 1'b1;
    repeat (10) @(negedge clk);
    check_all_zero("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Frame 0 is silent; constant tone latched into frame 1.
    push_frame(32'd0);
    audio_left  = 16'h1FFF;
    audio_right = 16'hE000;
    push_frame({1'b0, 16'h1FFF, 15'h7000});

    // Delay-bit check: right LSB shows up in slot 0 of the following frame.
    wait_at(1, 100);
    audio_left  = 16'h8001;
    audio_right = 16'h0001;
    push_frame({1'b0, 16'h8001, 15'h0000});

    wait_at(2, 100);
    audio_left  = 16'hAAAA;
    audio_right = 16'h0000;
    push_frame({1'b1, 16'hAAAA, 15'h0000});

    // Mid-frame change must not disturb frame 3.
    wait_at(3, 300);
    audio_left = 16'h5555;
    push_frame({1'b0, 16'h5555, 15'h0000});

    // Silence for three frames.
    wait_at(4, 100);
    audio_left  = 16'h0000;
    audio_right = 16'h0000;
    push_frame(32'd0);
    push_frame(32'd0);
    push_frame(32'd0);

    // Bit 4 of left lands in slot 12, which covers cnt 200.
    wait_at(7, 100);
    audio_left = 16'h0010;
    push_frame({1'b0, 16'h0010, 15'h0000});

    wait_at(8, 200);
    check("sdin_before_reset", audio_sdin, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    mon_en = 1'b0;
    exp_q.delete();
    audio_left  = 16'hFFFF;
    audio_right = 16'hFFFF;
    repeat (3) @(negedge clk);
    check_all_zero("reset_hold");
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Restart: frame 0 zero despite nonzero inputs, then the latched sample.
    push_frame(32'd0);
    push_frame({1'b0, 16'hFFFF, 15'h7FFF});
    wait_at(1, 100);
    audio_left  = 16'h0000;
    audio_right = 16'h0000;
    push_frame({1'b1, 16'h0000, 15'h0000});

    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d expected bits left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
